// File: rtl/pipelined_shifter_rotator.sv
// Pipelined barrel shifter/rotator: one register stage per shift level, left operations run
// through a bit-reversed right-shift core, valid/ready handshake with global stall.
module pipelined_shifter_rotator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned LEVEL = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [LEVEL-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    // op[1]: rotate, op[0]: left
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] data_q [LEVEL];
    logic [WIDTH-1:0] data_d [LEVEL];
    logic [TAG_W-1:0] tag_q  [LEVEL];
    logic [TAG_W-1:0] tag_d  [LEVEL];
    logic             valid_q[LEVEL];
    logic             valid_d[LEVEL];
    logic             carry_q[LEVEL];
    logic             carry_d[LEVEL];
    // The last stage holds only the result, so op and remaining shift bits stop one short.
    logic [1:0]       op_q   [LEVEL-1];
    logic [1:0]       op_d   [LEVEL-1];
    logic [LEVEL-1:0] b_q    [LEVEL-1];
    logic [LEVEL-1:0] b_d    [LEVEL-1];
    logic             zero_q;
    logic             zero_d;

    logic [WIDTH-1:0] src_data [LEVEL];
    logic [1:0]       src_op   [LEVEL];
    logic [LEVEL-1:0] src_b    [LEVEL];
    logic [TAG_W-1:0] src_tag  [LEVEL];
    logic             src_valid[LEVEL];
    logic             src_carry[LEVEL];
    logic [WIDTH-1:0] moved    [LEVEL];
    logic [WIDTH-1:0] lost     [LEVEL];
    logic [WIDTH-1:0] result;
    logic             en;

    assign en       = !(valid_q[LEVEL-1] && !out_ready);
    assign in_ready = en;

    always_comb begin
        src_data[0]  = in_op[0] ? bit_rev(in_a) : in_a;
        src_op[0]    = in_op;
        src_b[0]     = in_b;
        src_tag[0]   = in_tag;
        src_valid[0] = in_valid;
        src_carry[0] = 1'b0;
        for (int k = 1; k < LEVEL; k++) begin
            src_data[k]  = data_q[k-1];
            src_op[k]    = op_q[k-1];
            src_b[k]     = b_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_valid[k] = valid_q[k-1];
            src_carry[k] = carry_q[k-1];
        end

        for (int k = 0; k < LEVEL; k++) begin
            if (src_op[k][1]) begin
                moved[k] = (src_data[k] >> (1 << k)) | (src_data[k] << (WIDTH - (1 << k)));
            end else begin
                moved[k] = src_data[k] >> (1 << k);
            end
            // Bit 0 of lost is the last bit this stage pushes out; the highest active
            // stage therefore leaves a[b-1] (of the possibly reversed operand) as carry.
            lost[k]    = src_data[k] >> ((1 << k) - 1);
            data_d[k]  = src_b[k][0] ? moved[k] : src_data[k];
            tag_d[k]   = src_tag[k];
            valid_d[k] = src_valid[k];
            if (src_op[k][1]) begin
                carry_d[k] = 1'b0;
            end else begin
                carry_d[k] = src_b[k][0] ? lost[k][0] : src_carry[k];
            end
        end

        for (int k = 0; k < LEVEL - 1; k++) begin
            op_d[k] = src_op[k];
            b_d[k]  = src_b[k] >> 1;
        end

        result           = src_op[LEVEL-1][0] ? bit_rev(data_d[LEVEL-1]) : data_d[LEVEL-1];
        data_d[LEVEL-1]  = result;
        zero_d           = (result == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LEVEL; k++) begin
                data_q[k]  <= '0;
                tag_q[k]   <= '0;
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
            end
            for (int k = 0; k < LEVEL - 1; k++) begin
                op_q[k] <= '0;
                b_q[k]  <= '0;
            end
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < LEVEL; k++) begin
                data_q[k]  <= data_d[k];
                tag_q[k]   <= tag_d[k];
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
            end
            for (int k = 0; k < LEVEL - 1; k++) begin
                op_q[k] <= op_d[k];
                b_q[k]  <= b_d[k];
            end
            zero_q <= zero_d;
        end
    end

    assign out_valid = valid_q[LEVEL-1];
    assign out_y     = data_q[LEVEL-1];
    assign out_carry = carry_q[LEVEL-1];
    assign out_tag   = tag_q[LEVEL-1];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_shifter_rotator.sv
// Directed bench for pipelined_shifter_rotator: an 8-bit and a 32-bit instance, checked
// against hand-computed vectors and a bitwise reference model.
module tb_pipelined_shifter_rotator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_zero, out_carry;
    logic [7:0] in_a, out_y;
    logic [2:0] in_b;
    logic [1:0] in_op;
    logic [3:0] in_tag, out_tag;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_zero, w_out_carry;
    logic [31:0] w_in_a, w_out_y;
    logic [4:0]  w_in_b;
    logic [1:0]  w_in_op;
    logic [5:0]  w_in_tag, w_out_tag;

    pipelined_shifter_rotator #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_zero(out_zero), .out_carry(out_carry), .out_tag(out_tag)
    );

    pipelined_shifter_rotator #(.WIDTH(32), .TAG_W(6)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
        .in_op(w_in_op), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_y(w_out_y),
        .out_zero(w_out_zero), .out_carry(w_out_carry), .out_tag(w_out_tag)
    );

    typedef struct {
        logic [31:0] y;
        logic        zero;
        logic        carry;
        logic [7:0]  tag;
        int          cyc;
    } emit_t;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    emit_t emit8[$];
    emit_t emit32[$];
    int    acc8[$];
    int    acc32[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc8.push_back(cyc);
            if (out_valid && out_ready)
                emit8.push_back('{y: 32'(out_y), zero: out_zero, carry: out_carry,
                                  tag: 8'(out_tag), cyc: cyc});
            if (w_in_valid && w_in_ready) acc32.push_back(cyc);
            if (w_out_valid && w_out_ready)
                emit32.push_back('{y: w_out_y, zero: w_out_zero, carry: w_out_carry,
                                   tag: 8'(w_out_tag), cyc: cyc});
        end
    end

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Returns {carry, y}; built bit by bit from the operation definitions.
    function automatic logic [32:0] model(input logic [31:0] a, input int b,
                                          input logic [1:0] op, input int w);
        logic [31:0] y;
        logic        c;
        y = '0;
        c = 1'b0;
        for (int i = 0; i < w; i++) begin
            case (op)
                2'd0:    y[i] = (i + b < w) ? a[i+b] : 1'b0;
                2'd1:    y[i] = (i >= b) ? a[i-b] : 1'b0;
                2'd2:    y[i] = a[(i+b)%w];
                default: y[i] = a[(i-b+w)%w];
            endcase
        end
        if (b != 0 && op == 2'd0) c = a[b-1];
        if (b != 0 && op == 2'd1) c = a[w-b];
        return {c, y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_emit8(input int n, input string name);
        for (int t = 0; t < 40 && emit8.size() < n; t++) step();
        check_eq(name, 64'(emit8.size()), 64'(n));
    endtask

    task automatic clear_q();
        emit8.delete(); acc8.delete(); emit32.delete(); acc32.delete();
    endtask

    logic [7:0] t1_y[4]     = '{8'h12, 8'hB0, 8'hD2, 8'hB4};
    logic       t1_c[4]     = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] s_a[12];
    logic [2:0] s_b[12];
    logic [1:0] s_op[12];
    logic [32:0] m;

    initial begin
        int    idx;
        int    stall_cnt;
        int    stall_left;
        bit    stall_started;
        bit    acc_now;
        logic [7:0] snap_y;
        logic [3:0] snap_tag;
        logic       snap_zero, snap_carry;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_op = '0; w_in_tag = '0;
        w_out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_y", 64'(out_y), 64'd0);
        check_eq("rst_out_zero", 64'(out_zero), 64'd0);
        check_eq("rst_out_carry", 64'(out_carry), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back SRL/SLL/ROR/ROL of 0x96 by 3.
        clear_q();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 8'h96; in_b = 3'd3; in_op = 2'(i); in_tag = 4'(i + 1);
            step();
        end
        in_valid = 1'b0;
        wait_emit8(4, "t1_count");
        for (int i = 0; i < 4; i++) begin
            if (i < emit8.size() && i < acc8.size()) begin
                check_eq("t1_y", 64'(emit8[i].y), 64'(t1_y[i]));
                check_eq("t1_carry", 64'(emit8[i].carry), 64'(t1_c[i]));
                check_eq("t1_tag", 64'(emit8[i].tag), 64'(i + 1));
                check_eq("t1_latency", 64'(emit8[i].cyc - acc8[i]), 64'd3);
                check_eq("t1_consec", 64'(emit8[i].cyc - emit8[0].cyc), 64'(i));
            end
        end

        // Boundary vectors: SLL 0x80 by 1, ROR 0x01 by 0.
        clear_q();
        in_valid = 1'b1; in_a = 8'h80; in_b = 3'd1; in_op = 2'd1; in_tag = 4'd5;
        step();
        in_a = 8'h01; in_b = 3'd0; in_op = 2'd2; in_tag = 4'd6;
        step();
        in_valid = 1'b0;
        wait_emit8(2, "t2_count");
        if (emit8.size() >= 2) begin
            check_eq("t2_sll_y", 64'(emit8[0].y), 64'h00);
            check_eq("t2_sll_zero", 64'(emit8[0].zero), 64'd1);
            check_eq("t2_sll_carry", 64'(emit8[0].carry), 64'd1);
            check_eq("t2_ror_y", 64'(emit8[1].y), 64'h01);
            check_eq("t2_ror_zero", 64'(emit8[1].zero), 64'd0);
            check_eq("t2_ror_carry", 64'(emit8[1].carry), 64'd0);
        end

        // Eight ops with a 5-cycle downstream stall once results start arriving.
        clear_q();
        for (int i = 0; i < 8; i++) begin
            s_a[i] = 8'h96 ^ 8'(i * 37); s_b[i] = 3'((i * 3) % 8); s_op[i] = 2'(i % 4);
        end
        idx = 0; stall_started = 0; stall_left = 0; stall_cnt = 0;
        snap_y = '0; snap_tag = '0; snap_zero = 1'b0; snap_carry = 1'b0;
        for (int t = 0; t < 60 && emit8.size() < 8; t++) begin
            if (!stall_started && out_valid) begin
                stall_started = 1; stall_left = 5;
                snap_y = out_y; snap_tag = out_tag; snap_zero = out_zero; snap_carry = out_carry;
            end
            out_ready = (stall_left == 0);
            if (idx < 8) begin
                in_valid = 1'b1; in_a = s_a[idx]; in_b = s_b[idx]; in_op = s_op[idx];
                in_tag = 4'(idx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                check_eq("t3_stall_in_ready", 64'(in_ready), 64'd0);
                check_eq("t3_stall_valid", 64'(out_valid), 64'd1);
                check_eq("t3_stall_y", 64'(out_y), 64'(snap_y));
                check_eq("t3_stall_tag", 64'(out_tag), 64'(snap_tag));
                check_eq("t3_stall_flags", 64'({out_zero, out_carry}),
                         64'({snap_zero, snap_carry}));
                stall_left--;
                stall_cnt++;
            end
            acc_now = in_valid && in_ready;
            step();
            if (acc_now) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_eq("t3_stall_cycles", 64'(stall_cnt), 64'd5);
        check_eq("t3_count", 64'(emit8.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < emit8.size()) begin
                m = model(32'(s_a[i]), int'(s_b[i]), s_op[i], 8);
                check_eq("t3_tag", 64'(emit8[i].tag), 64'(i));
                check_eq("t3_y", 64'(emit8[i].y), 64'(m[7:0]));
                check_eq("t3_carry", 64'(emit8[i].carry), 64'(m[32]));
                check_eq("t3_zero", 64'(emit8[i].zero), 64'(m[7:0] == 8'h00));
            end
        end

        // Random input gaps, downstream always ready.
        clear_q();
        for (int i = 0; i < 12; i++) begin
            s_a[i] = 8'($urandom); s_b[i] = 3'($urandom_range(0, 7)); s_op[i] = 2'($urandom);
        end
        idx = 0;
        for (int t = 0; t < 100 && idx < 12; t++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = s_a[idx]; in_b = s_b[idx]; in_op = s_op[idx]; in_tag = 4'(idx);
            #1;
            acc_now = in_valid && in_ready;
            step();
            if (acc_now) idx++;
        end
        in_valid = 1'b0;
        wait_emit8(12, "t4_count");
        for (int i = 0; i < 12; i++) begin
            if (i < emit8.size() && i < acc8.size()) begin
                m = model(32'(s_a[i]), int'(s_b[i]), s_op[i], 8);
                check_eq("t4_tag", 64'(emit8[i].tag), 64'(i));
                check_eq("t4_y", 64'(emit8[i].y), 64'(m[7:0]));
                check_eq("t4_carry", 64'(emit8[i].carry), 64'(m[32]));
                check_eq("t4_latency", 64'(emit8[i].cyc - acc8[i]), 64'd3);
            end
        end

        // Reset with three ops in flight: nothing may come out afterwards.
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 8'hF0 + 8'(i); in_b = 3'd1; in_op = 2'd0;
            in_tag = 4'(9 + i);
            step();
        end
        in_valid = 1'b0;
        check_eq("t5_inflight_valid", 64'(out_valid), 64'd1);
        check_eq("t5_accepts", 64'(acc8.size()), 64'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check_eq("t5_out_valid", 64'(out_valid), 64'd0);
        check_eq("t5_out_y", 64'(out_y), 64'd0);
        check_eq("t5_out_tag", 64'(out_tag), 64'd0);
        check_eq("t5_flags", 64'({out_zero, out_carry}), 64'd0);
        check_eq("t5_in_ready", 64'(in_ready), 64'd1);
        for (int t = 0; t < 6; t++) step();
        check_eq("t5_no_emit", 64'(emit8.size()), 64'd0);

        // 32-bit instance: every amount for every op on 0x8000_0001.
        clear_q();
        for (int i = 0; i < 128; i++) begin
            w_in_valid = 1'b1; w_in_a = 32'h8000_0001; w_in_b = 5'(i % 32);
            w_in_op = 2'(i / 32); w_in_tag = 6'(i);
            step();
        end
        w_in_valid = 1'b0;
        for (int t = 0; t < 40 && emit32.size() < 128; t++) step();
        check_eq("t6_count", 64'(emit32.size()), 64'd128);
        for (int i = 0; i < 128; i++) begin
            if (i < emit32.size() && i < acc32.size()) begin
                m = model(32'h8000_0001, i % 32, 2'(i / 32), 32);
                check_eq("t6_y", 64'(emit32[i].y), 64'(m[31:0]));
                check_eq("t6_carry", 64'(emit32[i].carry), 64'(m[32]));
                check_eq("t6_zero", 64'(emit32[i].zero), 64'(m[31:0] == 32'd0));
                check_eq("t6_tag", 64'(emit32[i].tag), 64'(i % 64));
                check_eq("t6_latency", 64'(emit32[i].cyc - acc32[i]), 64'd5);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
